// File: rtl/branch_ctrl_pkg.sv
// Shared encodings for the branch/jump sequencer and its condition mux.
package branch_ctrl_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_COND  = 2'b00,
        MODE_UNCON = 2'b01,
        MODE_ABS   = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EVAL   = 3'd1,
        ST_ADJ    = 3'd2,
        ST_FIX    = 3'd3,
        ST_ABS_HI = 3'd4,
        ST_ABS_LD = 3'd5
    } state_e;

endpackage

// File: rtl/branch_ctrl_if.sv
// Decoder <-> branch sequencer request/response bundle.
interface branch_ctrl_if
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned PAGE_W = 8,
    parameter int unsigned NFLAGS = 8,
    parameter int unsigned SEL_W  = (NFLAGS > 1) ? $clog2(NFLAGS) : 1
);
    logic              start;
    mode_e             mode;
    logic [SEL_W-1:0]  cond_sel;
    logic              cond_val;
    logic [NFLAGS-1:0] status;
    logic [ADDR_W-1:0] pc_in;
    logic [PAGE_W-1:0] operand;
    logic              op_valid;

    logic              busy;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_next;
    logic              done;
    logic              taken;
    logic              page_cross;

    modport master (
        output start, mode, cond_sel, cond_val, status, pc_in, operand, op_valid,
        input  busy, pc_load, pc_next, done, taken, page_cross
    );

    modport slave (
        input  start, mode, cond_sel, cond_val, status, pc_in, operand, op_valid,
        output busy, pc_load, pc_next, done, taken, page_cross
    );
endinterface

// File: rtl/branch_cond.sv
// Flag select plus mode qualification; shared with the decoder skip logic.
module branch_cond
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned NFLAGS = 8,
    parameter int unsigned SEL_W  = (NFLAGS > 1) ? $clog2(NFLAGS) : 1
) (
    input  mode_e             mode,
    input  logic [SEL_W-1:0]  sel,
    input  logic              val,
    input  logic [NFLAGS-1:0] status,
    output logic              cond_c
);
    always_comb begin
        cond_c = 1'b0;
        unique case (mode)
            MODE_COND:           cond_c = (status[sel] == val);
            MODE_UNCON, MODE_ABS: cond_c = 1'b1;
            default:             cond_c = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_ctrl.sv
// Branch/jump sequencer: evaluates the condition, computes the target and
// issues a single-cycle PC load, with an extra cycle on relative page cross.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned PAGE_W = 8,
    parameter int unsigned NFLAGS = 8
) (
    input  logic         clk,
    input  logic         rst,
    branch_ctrl_if.slave bus
);
    localparam int unsigned SEL_W = (NFLAGS > 1) ? $clog2(NFLAGS) : 1;

    state_e            state;
    mode_e             mode_q;
    logic              cond_q;
    logic [ADDR_W-1:0] pc_q;
    logic [PAGE_W-1:0] lo_q;

    logic              cond_c;
    logic [ADDR_W-1:0] target_c;
    logic              cross_c;

    branch_cond #(.NFLAGS(NFLAGS), .SEL_W(SEL_W)) u_cond (
        .mode   (bus.mode),
        .sel    (bus.cond_sel),
        .val    (bus.cond_val),
        .status (bus.status),
        .cond_c (cond_c)
    );

    // Relative target wraps modulo 2^ADDR_W; page is everything above the offset bits.
    assign target_c = pc_q + ADDR_W'($signed(lo_q));
    assign cross_c  = (target_c[ADDR_W-1:PAGE_W] != pc_q[ADDR_W-1:PAGE_W]);

    // Outputs are registered as the Moore outputs of the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            mode_q         <= MODE_COND;
            cond_q         <= 1'b0;
            pc_q           <= '0;
            lo_q           <= '0;
            bus.busy       <= 1'b0;
            bus.pc_load    <= 1'b0;
            bus.pc_next    <= '0;
            bus.done       <= 1'b0;
            bus.taken      <= 1'b0;
            bus.page_cross <= 1'b0;
        end else begin
            bus.pc_load    <= 1'b0;
            bus.done       <= 1'b0;
            bus.taken      <= 1'b0;
            bus.page_cross <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        mode_q   <= bus.mode;
                        cond_q   <= cond_c;
                        pc_q     <= bus.pc_in;
                        lo_q     <= bus.operand;
                        bus.busy <= 1'b1;
                        bus.done <= ~cond_c;
                        state    <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (!cond_q) begin
                        bus.busy <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (mode_q == MODE_ABS) begin
                        state <= ST_ABS_HI;
                    end else begin
                        state <= ST_ADJ;
                        if (!cross_c) begin
                            bus.pc_load <= 1'b1;
                            bus.pc_next <= target_c;
                            bus.done    <= 1'b1;
                            bus.taken   <= 1'b1;
                        end
                    end
                end
                ST_ADJ: begin
                    if (cross_c) begin
                        bus.pc_load    <= 1'b1;
                        bus.pc_next    <= target_c;
                        bus.done       <= 1'b1;
                        bus.taken      <= 1'b1;
                        bus.page_cross <= 1'b1;
                        state          <= ST_FIX;
                    end else begin
                        bus.busy <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                ST_ABS_HI: begin
                    if (bus.op_valid) begin
                        bus.pc_load <= 1'b1;
                        bus.pc_next <= ADDR_W'({bus.operand, lo_q});
                        bus.done    <= 1'b1;
                        bus.taken   <= 1'b1;
                        state       <= ST_ABS_LD;
                    end
                end
                ST_FIX, ST_ABS_LD: begin
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl with hand-computed expected targets and timing.
module tb_branch_ctrl;
    import branch_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    branch_ctrl_if bus ();

    branch_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.start    = 1'b0;
        bus.mode     = MODE_COND;
        bus.cond_sel = 3'd0;
        bus.cond_val = 1'b0;
        bus.status   = 8'h00;
        bus.pc_in    = 16'h0000;
        bus.operand  = 8'h00;
        bus.op_valid = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "/busy"},    32'(bus.busy),    32'd0);
        check({tag, "/pc_load"}, 32'(bus.pc_load), 32'd0);
        check({tag, "/done"},    32'(bus.done),    32'd0);
    endtask

    task automatic request(input mode_e m, input logic [2:0] sel, input logic val,
                           input logic [7:0] st, input logic [15:0] pc, input logic [7:0] op);
        bus.mode     = m;
        bus.cond_sel = sel;
        bus.cond_val = val;
        bus.status   = st;
        bus.pc_in    = pc;
        bus.operand  = op;
        bus.start    = 1'b1;
        tick;
        idle_inputs;
    endtask

    // Relative or reserved request followed cycle by cycle to completion.
    task automatic run_rel(input string tag, input mode_e m, input logic [2:0] sel,
                           input logic val, input logic [7:0] st, input logic [15:0] pc,
                           input logic [7:0] op, input logic exp_taken, input logic exp_cross,
                           input logic [15:0] exp_pc);
        request(m, sel, val, st, pc, op);
        check({tag, "/c1_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "/c1_pc_load"}, 32'(bus.pc_load), 32'd0);
        if (!exp_taken) begin
            check({tag, "/c1_done"}, 32'(bus.done), 32'd1);
            check({tag, "/c1_taken"}, 32'(bus.taken), 32'd0);
        end else begin
            check({tag, "/c1_done"}, 32'(bus.done), 32'd0);
            tick;
            if (exp_cross) begin
                check({tag, "/c2_pc_load"}, 32'(bus.pc_load), 32'd0);
                check({tag, "/c2_done"}, 32'(bus.done), 32'd0);
                tick;
            end
            check({tag, "/ld_pc_load"}, 32'(bus.pc_load), 32'd1);
            check({tag, "/ld_done"}, 32'(bus.done), 32'd1);
            check({tag, "/ld_taken"}, 32'(bus.taken), 32'd1);
            check({tag, "/ld_busy"}, 32'(bus.busy), 32'd1);
            check({tag, "/ld_page_cross"}, 32'(bus.page_cross), 32'(exp_cross));
            check({tag, "/ld_pc_next"}, 32'(bus.pc_next), 32'(exp_pc));
        end
        tick;
        check_quiet({tag, "/after"});
        if (exp_taken) check({tag, "/hold_pc_next"}, 32'(bus.pc_next), 32'(exp_pc));
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs;
        repeat (2) tick;
        check_quiet("reset");
        check("reset/taken", 32'(bus.taken), 32'd0);
        check("reset/page_cross", 32'(bus.page_cross), 32'd0);
        check("reset/pc_next", 32'(bus.pc_next), 32'h0);
        rst = 1'b0;
        tick;
        check_quiet("post_reset");

        run_rel("cond_same", MODE_COND, 3'd1, 1'b1, 8'h02, 16'h1234, 8'h10, 1'b1, 1'b0, 16'h1244);
        run_rel("cond_back", MODE_COND, 3'd1, 1'b1, 8'h02, 16'h1205, 8'hF0, 1'b1, 1'b1, 16'h11F5);
        run_rel("cond_false", MODE_COND, 3'd1, 1'b1, 8'h00, 16'h3000, 8'h10, 1'b0, 1'b0, 16'h0000);
        check("cond_false/pc_next_held", 32'(bus.pc_next), 32'h11F5);
        run_rel("cond_val0_false", MODE_COND, 3'd7, 1'b0, 8'h80, 16'h4000, 8'h04, 1'b0, 1'b0, 16'h0000);
        run_rel("cond_val0_true", MODE_COND, 3'd7, 1'b0, 8'h7F, 16'h2000, 8'h7F, 1'b1, 1'b0, 16'h207F);
        run_rel("neg128_same", MODE_UNCON, 3'd0, 1'b0, 8'h00, 16'h1280, 8'h80, 1'b1, 1'b0, 16'h1200);
        run_rel("uncon_wrap", MODE_UNCON, 3'd0, 1'b0, 8'h00, 16'hFFF8, 8'h10, 1'b1, 1'b1, 16'h0008);
        run_rel("reserved", MODE_RSVD, 3'd0, 1'b0, 8'hFF, 16'h5000, 8'h10, 1'b0, 1'b0, 16'h0000);

        // Absolute jump with stray op_valid in EVAL and start pulses while busy.
        request(MODE_ABS, 3'd0, 1'b0, 8'h00, 16'h6000, 8'h00);
        check("abs/c1_busy", 32'(bus.busy), 32'd1);
        check("abs/c1_done", 32'(bus.done), 32'd0);
        bus.op_valid = 1'b1;
        bus.operand  = 8'h55;
        bus.start    = 1'b1;
        tick;
        bus.op_valid = 1'b0;
        bus.mode     = MODE_UNCON;
        bus.pc_in    = 16'h0100;
        bus.operand  = 8'h02;
        check("abs/c2_pc_load", 32'(bus.pc_load), 32'd0);
        check("abs/c2_busy", 32'(bus.busy), 32'd1);
        tick;
        idle_inputs;
        bus.op_valid = 1'b1;
        bus.operand  = 8'hC0;
        check("abs/c3_pc_load", 32'(bus.pc_load), 32'd0);
        check("abs/c3_done", 32'(bus.done), 32'd0);
        tick;
        idle_inputs;
        check("abs/ld_pc_load", 32'(bus.pc_load), 32'd1);
        check("abs/ld_done", 32'(bus.done), 32'd1);
        check("abs/ld_taken", 32'(bus.taken), 32'd1);
        check("abs/ld_page_cross", 32'(bus.page_cross), 32'd0);
        check("abs/ld_pc_next", 32'(bus.pc_next), 32'hC000);
        for (int i = 0; i < 3; i++) begin
            tick;
            check_quiet($sformatf("abs/idle%0d", i));
        end
        check("abs/pc_next_held", 32'(bus.pc_next), 32'hC000);

        // Reset while waiting in ADJ on a page-crossing branch.
        request(MODE_COND, 3'd1, 1'b1, 8'h02, 16'h1205, 8'hF0);
        tick;
        check("abort/adj_busy", 32'(bus.busy), 32'd1);
        check("abort/adj_pc_load", 32'(bus.pc_load), 32'd0);
        rst = 1'b1;
        #1;
        check_quiet("abort/async");
        check("abort/pc_next", 32'(bus.pc_next), 32'h0);
        tick;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            check_quiet($sformatf("abort/idle%0d", i));
        end
        run_rel("after_abort", MODE_COND, 3'd1, 1'b1, 8'h02, 16'h1234, 8'h10, 1'b1, 1'b0, 16'h1244);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
